// File: rtl/alu_writeback_pkg.sv
// Shared CPU datapath definitions: operand-mode encodings, widths, fixed
// destination and write-back state enum.
package alu_writeback_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int FIXED_DEST = 8;

  typedef enum logic [1:0] {
    SRC_RR  = 2'b00,
    SRC_RU4 = 2'b01,
    SRC_U8L = 2'b10,
    SRC_U8H = 2'b11
  } src_mode_e;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_HELD  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/alu_writeback_fwd_match.sv
// Forwarding match for one operand port: the hold register (younger) takes
// priority over the output stage; no hit yields zero data.
module wb_fwd_match #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              hold_valid_i,
  input  logic [ADDR_W-1:0] hold_addr_i,
  input  logic [DATA_W-1:0] hold_data_i,
  input  logic              out_valid_i,
  input  logic [ADDR_W-1:0] out_addr_i,
  input  logic [DATA_W-1:0] out_data_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (hold_valid_i && (hold_addr_i == addr_i)) begin
      hit_o  = 1'b1;
      data_o = hold_data_i;
    end else if (out_valid_i && (out_addr_i == addr_i)) begin
      hit_o  = 1'b1;
      data_o = out_data_i;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Result write-back stage: arbitrates the register-file write port between
// loads and ALU results, buffering one ALU result. Macro WB_BYPASS_EN adds FWD_* ports.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int FIXED_DEST_P = FIXED_DEST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid_i,
  output logic                alu_ready_o,
  input  logic [DATA_W_P-1:0] alu_result_i,
  input  logic                alu_wen_i,
  input  logic [1:0]          sourcex_i,
  input  logic [ADDR_W_P-1:0] arg_a_i,
  input  logic                mem_valid_i,
  input  logic [DATA_W_P-1:0] mem_data_i,
  input  logic [ADDR_W_P-1:0] mem_dest_i,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W_P-1:0] fwd_addr_a_i,
  input  logic [ADDR_W_P-1:0] fwd_addr_b_i,
  output logic                fwd_hit_a_o,
  output logic                fwd_hit_b_o,
  output logic [DATA_W_P-1:0] fwd_data_a_o,
  output logic [DATA_W_P-1:0] fwd_data_b_o,
`endif
  output logic                reg_we_o,
  output logic [ADDR_W_P-1:0] reg_waddr_o,
  output logic [DATA_W_P-1:0] reg_wdata_o,
  output logic                busy_o
);

  localparam logic [ADDR_W_P-1:0] FIXED_ADDR = ADDR_W_P'(FIXED_DEST_P);

  wb_state_e             state_q, state_d;
  logic [DATA_W_P-1:0]   hold_data_q, hold_data_d;
  logic [ADDR_W_P-1:0]   hold_addr_q, hold_addr_d;
  logic                  reg_we_q, reg_we_d;
  logic [ADDR_W_P-1:0]   reg_waddr_q, reg_waddr_d;
  logic [DATA_W_P-1:0]   reg_wdata_q, reg_wdata_d;
  logic                  alu_write;
  logic [ADDR_W_P-1:0]   alu_dest;

  assign alu_ready_o = (state_q == WB_EMPTY);
  assign busy_o      = (state_q == WB_HELD);
  assign alu_write   = alu_valid_i & alu_ready_o & alu_wen_i;

  always_comb begin
    unique case (src_mode_e'(sourcex_i))
      SRC_U8L, SRC_U8H: alu_dest = FIXED_ADDR;
      default:          alu_dest = arg_a_i;
    endcase
  end

  // Loads always win the port; an ALU result colliding with a load is parked
  // so write order still matches arrival order.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    if (mem_valid_i) begin
      reg_we_d    = 1'b1;
      reg_waddr_d = mem_dest_i;
      reg_wdata_d = mem_data_i;
      if (alu_write) begin
        hold_data_d = alu_result_i;
        hold_addr_d = alu_dest;
        state_d     = WB_HELD;
      end
    end else if (state_q == WB_HELD) begin
      reg_we_d    = 1'b1;
      reg_waddr_d = hold_addr_q;
      reg_wdata_d = hold_data_q;
      state_d     = WB_EMPTY;
    end else if (alu_write) begin
      reg_we_d    = 1'b1;
      reg_waddr_d = alu_dest;
      reg_wdata_d = alu_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WB_EMPTY;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;

`ifdef WB_BYPASS_EN
  wb_fwd_match #(.DATA_W(DATA_W_P), .ADDR_W(ADDR_W_P)) u_fwd_a (
    .addr_i       (fwd_addr_a_i),
    .hold_valid_i (busy_o),
    .hold_addr_i  (hold_addr_q),
    .hold_data_i  (hold_data_q),
    .out_valid_i  (reg_we_q),
    .out_addr_i   (reg_waddr_q),
    .out_data_i   (reg_wdata_q),
    .hit_o        (fwd_hit_a_o),
    .data_o       (fwd_data_a_o)
  );

  wb_fwd_match #(.DATA_W(DATA_W_P), .ADDR_W(ADDR_W_P)) u_fwd_b (
    .addr_i       (fwd_addr_b_i),
    .hold_valid_i (busy_o),
    .hold_addr_i  (hold_addr_q),
    .hold_data_i  (hold_data_q),
    .out_valid_i  (reg_we_q),
    .out_addr_i   (reg_waddr_q),
    .out_data_i   (reg_wdata_q),
    .hit_o        (fwd_hit_b_o),
    .data_o       (fwd_data_b_o)
  );
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed, table-driven bench for alu_writeback; optional forwarding checks
// compile in when WB_BYPASS_EN is defined.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [15:0] alu_result = '0;
  logic        alu_wen = 1'b0;
  logic [1:0]  sourcex = '0;
  logic [3:0]  arg_a = '0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic [3:0]  mem_dest = '0;
  logic        reg_we;
  logic [3:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        busy;
`ifdef WB_BYPASS_EN
  logic [3:0]  fwd_addr_a = '0;
  logic [3:0]  fwd_addr_b = '0;
  logic        fwd_hit_a, fwd_hit_b;
  logic [15:0] fwd_data_a, fwd_data_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid_i  (alu_valid),
    .alu_ready_o  (alu_ready),
    .alu_result_i (alu_result),
    .alu_wen_i    (alu_wen),
    .sourcex_i    (sourcex),
    .arg_a_i      (arg_a),
    .mem_valid_i  (mem_valid),
    .mem_data_i   (mem_data),
    .mem_dest_i   (mem_dest),
`ifdef WB_BYPASS_EN
    .fwd_addr_a_i (fwd_addr_a),
    .fwd_addr_b_i (fwd_addr_b),
    .fwd_hit_a_o  (fwd_hit_a),
    .fwd_hit_b_o  (fwd_hit_b),
    .fwd_data_a_o (fwd_data_a),
    .fwd_data_b_o (fwd_data_b),
`endif
    .reg_we_o     (reg_we),
    .reg_waddr_o  (reg_waddr),
    .reg_wdata_o  (reg_wdata),
    .busy_o       (busy)
  );

  typedef struct {
    logic        av;
    logic        wen;
    logic [1:0]  src;
    logic [3:0]  arg;
    logic [15:0] res;
    logic        mv;
    logic [15:0] md;
    logic [3:0]  mdst;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic        e_busy;
    logic        e_ready;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic we, input logic [3:0] addr,
                               input logic [15:0] data, input logic bsy, input logic rdy);
    check({tag, ".reg_we"},    32'(reg_we),    32'(we));
    check({tag, ".reg_waddr"}, 32'(reg_waddr), 32'(addr));
    check({tag, ".reg_wdata"}, 32'(reg_wdata), 32'(data));
    check({tag, ".busy"},      32'(busy),      32'(bsy));
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'(rdy));
  endtask

  task automatic drive(input logic av, input logic wen, input logic [1:0] src, input logic [3:0] arg,
                       input logic [15:0] res, input logic mv, input logic [15:0] md, input logic [3:0] mdst);
    @(negedge clk);
    alu_valid = av; alu_wen = wen; sourcex = src; arg_a = arg; alu_result = res;
    mem_valid = mv; mem_data = md; mem_dest = mdst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          av wen src   arg   res       mv  md        mdst  we addr  data     busy rdy
    vecs[0]  = '{1, 1, 2'b00, 4'd3, 16'h1234, 0, 16'h0000, 4'd0, 1, 4'd3, 16'h1234, 0, 1};
    vecs[1]  = '{1, 1, 2'b11, 4'd5, 16'hAB00, 0, 16'h0000, 4'd0, 1, 4'd8, 16'hAB00, 0, 1};
    vecs[2]  = '{0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0, 0, 4'd8, 16'hAB00, 0, 1};
    vecs[3]  = '{1, 1, 2'b00, 4'd2, 16'h5555, 1, 16'h0F0F, 4'd2, 1, 4'd2, 16'h0F0F, 1, 0};
    vecs[4]  = '{0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0, 1, 4'd2, 16'h5555, 0, 1};
    vecs[5]  = '{1, 1, 2'b01, 4'd6, 16'h0606, 1, 16'h0909, 4'd9, 1, 4'd9, 16'h0909, 1, 0};
    vecs[6]  = '{1, 1, 2'b00, 4'd7, 16'h7777, 1, 16'h0101, 4'd1, 1, 4'd1, 16'h0101, 1, 0};
    vecs[7]  = '{0, 0, 2'b00, 4'd0, 16'h0000, 1, 16'h0303, 4'd3, 1, 4'd3, 16'h0303, 1, 0};
    vecs[8]  = '{0, 0, 2'b00, 4'd0, 16'h0000, 1, 16'h0404, 4'd4, 1, 4'd4, 16'h0404, 1, 0};
    vecs[9]  = '{0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0, 1, 4'd6, 16'h0606, 0, 1};
    vecs[10] = '{1, 0, 2'b00, 4'd5, 16'hDEAD, 0, 16'h0000, 4'd0, 0, 4'd6, 16'h0606, 0, 1};
    vecs[11] = '{1, 0, 2'b00, 4'd5, 16'hBEEF, 1, 16'h0A0A, 4'd10, 1, 4'd10, 16'h0A0A, 0, 1};
    vecs[12] = '{0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0, 0, 4'd10, 16'h0A0A, 0, 1};
    vecs[13] = '{0, 0, 2'b00, 4'd0, 16'h0000, 1, 16'hFFFF, 4'd15, 1, 4'd15, 16'hFFFF, 0, 1};
    vecs[14] = '{1, 1, 2'b10, 4'd1, 16'h00C3, 0, 16'h0000, 4'd0, 1, 4'd8, 16'h00C3, 0, 1};

    // Reset state, checked while reset is still asserted.
    #12;
    check_outputs("reset", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
`ifdef WB_BYPASS_EN
    check("reset.fwd_hit_a", 32'(fwd_hit_a), 32'd0);
    check("reset.fwd_hit_b", 32'(fwd_hit_b), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].wen, vecs[i].src, vecs[i].arg, vecs[i].res,
            vecs[i].mv, vecs[i].md, vecs[i].mdst);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_addr,
                    vecs[i].e_data, vecs[i].e_busy, vecs[i].e_ready);
      $display("vec%0d: we=%0d addr=%0d data=0x%04h busy=%0d ready=%0d",
               i, reg_we, reg_waddr, reg_wdata, busy, alu_ready);
    end

    // Reset while HELD: held result must be discarded.
    drive(1, 1, 2'b00, 4'd12, 16'hCAFE, 1, 16'h1357, 4'd11);
    check_outputs("pre_rst_held", 1'b1, 4'd11, 16'h1357, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    drive(0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0);
    check_outputs("post_rst_idle1", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    drive(0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0);
    check_outputs("post_rst_idle2", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    $display("reset-mid-held: we=%0d busy=%0d", reg_we, busy);

`ifdef WB_BYPASS_EN
    // Hold register (dest 4 = 0x1111) and output stage (dest 4 = 0x2222) both match.
    fwd_addr_a = 4'd4;
    fwd_addr_b = 4'd7;
    drive(1, 1, 2'b00, 4'd4, 16'h1111, 1, 16'h2222, 4'd4);
    check("fwd1.hit_a",  32'(fwd_hit_a),  32'd1);
    check("fwd1.data_a", 32'(fwd_data_a), 32'h1111);
    check("fwd1.hit_b",  32'(fwd_hit_b),  32'd0);
    check("fwd1.data_b", 32'(fwd_data_b), 32'h0000);
    $display("fwd1: hit_a=%0d data_a=0x%04h hit_b=%0d data_b=0x%04h",
             fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
    // Next cycle only the output stage holds dest 4.
    fwd_addr_b = 4'd4;
    drive(0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0);
    check("fwd2.hit_b",  32'(fwd_hit_b),  32'd1);
    check("fwd2.data_b", 32'(fwd_data_b), 32'h1111);
    check("fwd2.busy",   32'(busy),       32'd0);
    $display("fwd2: hit_b=%0d data_b=0x%04h", fwd_hit_b, fwd_data_b);
    // Idle: nothing pending, no hit.
    drive(0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h0000, 4'd0);
    check("fwd3.hit_a",  32'(fwd_hit_a),  32'd0);
    check("fwd3.data_a", 32'(fwd_data_a), 32'h0000);
    $display("fwd3: hit_a=%0d data_a=0x%04h", fwd_hit_a, fwd_data_a);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Result write-back stage for the CPU datapath: the return path that closes the loop opened by operand selection. Accepts ALU results and memory load data, resolves the destination register from the same SOURCEX/ARG_A encoding the operand selector uses, arbitrates the single register-file write port, and buffers one ALU result when a load holds the port. Sits between the ALU/load unit and the register file write port.

## Interface
- DATA_W, 16, register/result width
- ADDR_W, 4, register address width
- FIXED_DEST, 8, destination register for SOURCEX = 10/11 (RA)

- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- ALU_VALID  in  1  ALU result offered this cycle
- ALU_READY  out  1  stage can accept an ALU result
- ALU_RESULT  in  DATA_W  ALU output
- ALU_WEN  in  1  result must be written (0 = flags-only op, accepted and dropped)
- SOURCEX  in  2  operand mode of the producing instruction
- ARG_A  in  ADDR_W  instruction Ra field
- MEM_VALID  in  1  load data valid; always accepted, no ready
- MEM_DATA  in  DATA_W  load data
- MEM_DEST  in  ADDR_W  load destination register
- REG_WE  out  1  register-file write enable (registered)
- REG_WADDR  out  ADDR_W  write address (registered)
- REG_WDATA  out  DATA_W  write data (registered)
- BUSY  out  1  an ALU result is held
- FWD_ADDR_A, FWD_ADDR_B  in  ADDR_W  operand addresses being read (WB_BYPASS_EN only)
- FWD_HIT_A, FWD_HIT_B  out  1  pending write matches address (WB_BYPASS_EN only)
- FWD_DATA_A, FWD_DATA_B  out  DATA_W  forwarded value (WB_BYPASS_EN only)

## Operation
- ALU destination: SOURCEX[1]=0 -> ARG_A; SOURCEX[1]=1 -> FIXED_DEST. SOURCEX[0] ignored.
- ALU accept = ALU_VALID & ALU_READY. ALU_READY = (state == EMPTY).
- States: EMPTY (hold register free), HELD (one ALU result buffered).
- Per-cycle output-stage load priority: MEM_VALID > held result > accepted ALU result with ALU_WEN=1. No candidate -> REG_WE <= 0; REG_WADDR/REG_WDATA hold last value.
- EMPTY, accept, ALU_WEN=1, MEM_VALID=1 -> load writes, ALU result/dest captured, -> HELD.
- EMPTY, accept, ALU_WEN=1, MEM_VALID=0 -> ALU written directly, stay EMPTY.
- Accept with ALU_WEN=0 -> no write, no hold, stay EMPTY.
- HELD, MEM_VALID=0 -> held result written, -> EMPTY. HELD, MEM_VALID=1 -> load written, remain HELD (unbounded under back-to-back loads; load unit guarantees gaps).
- Write order equals arrival order; same-register load then ALU result leaves ALU value final.
- BUSY = (state == HELD).

## Timing
- Reset: state EMPTY, REG_WE 0, REG_WADDR 0, REG_WDATA 0, BUSY 0, ALU_READY 1, hold register 0, FWD_HIT_* 0.
- Latency: accept/MEM_VALID at edge N -> REG_WE high cycle N+1. Held result: earliest one cycle after the last consecutive MEM_VALID.
- ALU_READY combinational from state only; no combinational path from ALU_VALID or MEM_VALID.
- Reset mid-HELD discards held result, no write issued.

## Configuration
- WB_BYPASS_EN defined: FWD_* ports present; FWD_HIT_x = hit on hold register (HELD, addr match) else output stage (REG_WE, addr match); hold register wins (younger). FWD_DATA_x = matching value, 0 when no hit. Purely combinational on registered state.
- Undefined: FWD_* ports absent; consumers stall on BUSY/REG_WE hazards.

## Structure
- Shared CPU package: SOURCEX encodings (SRC_RR=00, SRC_RU4=01, SRC_U8L=10, SRC_U8H=11), FIXED_DEST default, DATA_W/ADDR_W constants, state enum {WB_EMPTY, WB_HELD}.
- One sub-module natural: wb_fwd_match (address compare + priority mux), instantiated twice, only under WB_BYPASS_EN.

## Test plan
- ALU_VALID, SOURCEX=00, ARG_A=3, result 0x1234, WEN=1 -> next cycle REG_WE=1, REG_WADDR=3, REG_WDATA=0x1234.
- SOURCEX=11, ARG_A=5, result 0xAB00 -> REG_WADDR=8, REG_WDATA=0xAB00.
- Same cycle MEM_VALID dest 2 data 0x0F0F and ALU dest 2 data 0x5555 -> cycle+1 writes 0x0F0F, BUSY=1, ALU_READY=0; cycle+2 writes 0x5555, BUSY=0.
- HELD plus three consecutive MEM_VALID -> three loads written in order, held result written the cycle after the third.
- ALU_WEN=0 accepted -> REG_WE stays 0, state EMPTY; RESET_N low while HELD -> all outputs reset values, no held write afterward.
- WB_BYPASS_EN: HELD dest 4 = 0x1111, output stage dest 4 = 0x2222, FWD_ADDR_A=4 -> FWD_HIT_A=1, FWD_DATA_A=0x1111; FWD_ADDR_B=7 -> FWD_HIT_B=0, FWD_DATA_B=0.
